// File: rtl/pwl_activation_pipe.sv
// pwl_activation_pipe: 3-stage piecewise-linear sigmoid/tanh unit with valid/ready on both sides.
// Optional segment-index output o_seg is enabled by defining PWL_SEG_OUT_EN.
module pwl_activation_pipe #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_mode,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
`ifdef PWL_SEG_OUT_EN
   output logic [2:0]       o_seg,
`endif
   input  logic             i_ready
);
   localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
   localparam logic [WIDTH-1:0] TWO   = ONE << 1;
   localparam logic [WIDTH-1:0] THREE = ONE + TWO;
   localparam logic [WIDTH-1:0] FOUR  = ONE << 2;
   localparam logic [WIDTH-1:0] SIX   = FOUR + TWO;
   localparam logic [WIDTH-1:0] C0    = ONE >> 1;
   localparam logic [WIDTH-1:0] C1    = C0 + (ONE >> 3);
   localparam logic [WIDTH-1:0] C2    = C0 + (ONE >> 2);
   localparam logic [WIDTH-1:0] C3    = C2 + (ONE >> 4) + (ONE >> 5);
   localparam logic [WIDTH-1:0] C4    = C2 + (ONE >> 3) + (ONE >> 5);

   logic             en;
   logic             v1_q, v1_d, neg1_q, neg1_d, mode1_q, mode1_d;
   logic [WIDTH-1:0] a1_q, a1_d;
   logic             v2_q, v2_d, neg2_q, neg2_d, mode2_q, mode2_d;
   logic [WIDTH-1:0] s2_q, s2_d;
   logic [2:0]       seg2_q, seg2_d;
   logic             v3_q, v3_d;
   logic [WIDTH-1:0] y3_q, y3_d;
   logic [WIDTH-1:0] abs_x, s_n, t_n, y_n;
   logic [2:0]       seg_n;
   logic             sat;

   assign en      = !v3_q || i_ready;
   assign o_ready = en;
   assign o_valid = v3_q;
   assign o_data  = y3_q;

   // Stage 1: magnitude, tanh pre-scale; -2^(W-1) and tanh shift overflow become an all-ones (saturating) operand
   always_comb begin
      abs_x   = i_data[WIDTH-1] ? -i_data : i_data;
      sat     = abs_x[WIDTH-1] || (i_mode && abs_x[WIDTH-2]);
      v1_d    = en ? i_valid : v1_q;
      neg1_d  = en ? i_data[WIDTH-1] : neg1_q;
      mode1_d = en ? i_mode : mode1_q;
      a1_d    = !en ? a1_q : sat ? '1 : i_mode ? abs_x << 1 : abs_x;
   end

   // Stage 2: segment classification and slope/intercept evaluation
   always_comb begin
      seg_n   = a1_q < ONE ? 3'd0 : a1_q < TWO ? 3'd1 : a1_q < THREE ? 3'd2 :
                a1_q < FOUR ? 3'd3 : a1_q < SIX ? 3'd4 : 3'd7;
      s_n     = seg_n == 3'd0 ? (a1_q >> 2) + C0 :
                seg_n == 3'd1 ? (a1_q >> 3) + C1 :
                seg_n == 3'd2 ? (a1_q >> 4) + C2 :
                seg_n == 3'd3 ? (a1_q >> 5) + C3 :
                seg_n == 3'd4 ? (a1_q >> 6) + C4 : ONE;
      v2_d    = en ? v1_q : v2_q;
      neg2_d  = en ? neg1_q : neg2_q;
      mode2_d = en ? mode1_q : mode2_q;
      s2_d    = en ? s_n : s2_q;
      seg2_d  = en ? seg_n : seg2_q;
   end

   // Stage 3: symmetry for negative inputs, tanh = 2*sigmoid(2x) - 1
   always_comb begin
      t_n  = (s2_q << 1) - ONE;
      y_n  = mode2_q ? (neg2_q ? -t_n : t_n) : (neg2_q ? ONE - s2_q : s2_q);
      v3_d = en ? v2_q : v3_q;
      y3_d = en ? y_n : y3_q;
   end

   // Pipeline registers; everything clears on reset, discarding in-flight samples
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         neg1_q  <= 1'b0;
         mode1_q <= 1'b0;
         a1_q    <= '0;
         v2_q    <= 1'b0;
         neg2_q  <= 1'b0;
         mode2_q <= 1'b0;
         s2_q    <= '0;
         seg2_q  <= '0;
         v3_q    <= 1'b0;
         y3_q    <= '0;
      end else begin
         v1_q    <= v1_d;
         neg1_q  <= neg1_d;
         mode1_q <= mode1_d;
         a1_q    <= a1_d;
         v2_q    <= v2_d;
         neg2_q  <= neg2_d;
         mode2_q <= mode2_d;
         s2_q    <= s2_d;
         seg2_q  <= seg2_d;
         v3_q    <= v3_d;
         y3_q    <= y3_d;
      end
   end

`ifdef PWL_SEG_OUT_EN
   logic [2:0] seg3_q, seg3_d;

   assign o_seg = seg3_q;

   // Segment index travels with the result and holds under stall
   always_comb begin
      seg3_d = en ? seg2_q : seg3_q;
   end

   // Output segment register
   always_ff @(posedge clk) begin
      if (rst) seg3_q <= '0;
      else     seg3_q <= seg3_d;
   end
`else
   logic unused_seg;

   assign unused_seg = ^seg2_q;
`endif
endmodule

// File: tb/tb_pwl_activation_pipe.sv
// tb_pwl_activation_pipe: scoreboard bench for pwl_activation_pipe with hand-computed expected values.
module tb_pwl_activation_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] i_data = '0;
   logic        i_mode = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] o_data;
   logic        o_valid;
   logic        i_ready = 1'b0;
`ifdef PWL_SEG_OUT_EN
   logic [2:0]  o_seg;
`endif

   int checks = 0;
   int failures = 0;
   int run = 0;
   int max_run = 0;
   logic [31:0] exp_q[$];

   pwl_activation_pipe #(.WIDTH(32), .FRAC(24)) dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_mode(i_mode), .i_valid(i_valid),
      .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
`ifdef PWL_SEG_OUT_EN
      .o_seg(o_seg),
`endif
      .i_ready(i_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic send(input logic [31:0] x, input logic m, input logic [31:0] e);
      int n = 0;
      i_data = x;
      i_mode = m;
      i_valid = 1'b1;
      @(negedge clk);
      while (!o_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout got=o_ready_low want=o_ready_high");
      end
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout got=%0d_pending want=0", exp_q.size());
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Monitor: pops and compares on every output handshake
   always @(negedge clk) begin
      if (rst) run = 0;
      else begin
         run = o_valid ? run + 1 : 0;
         if (run > max_run) max_run = run;
         if (o_valid && i_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_output got=%h want=none", o_data);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (o_data !== e) begin
                  failures++;
                  $display("FAIL output got=%h want=%h", o_data, e);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_o_data", o_data, 32'd0);
      chk("rst_o_ready", {31'd0, o_ready}, 32'd1);
      @(posedge clk);
      #1;
      i_ready = 1'b1;
      send(32'h00000000, 1'b0, 32'h00800000);
      drain();
      send(32'h01000000, 1'b0, 32'h00C00000);
      send(32'hFF000000, 1'b0, 32'h00400000);
      send(32'h04000000, 1'b0, 32'h00F80000);
      send(32'h07000000, 1'b0, 32'h01000000);
      send(32'h80000000, 1'b0, 32'h00000000);
      send(32'h00800000, 1'b1, 32'h00800000);
      send(32'hFF800000, 1'b1, 32'hFF800000);
      send(32'h7FFFFFFF, 1'b1, 32'h01000000);
      drain();
      max_run = 0;
      send(32'h00400000, 1'b0, 32'h00900000);
      send(32'h00400000, 1'b1, 32'h00400000);
      send(32'h02000000, 1'b0, 32'h00E00000);
      send(32'hFF000000, 1'b1, 32'hFF400000);
      send(32'h03000000, 1'b0, 32'h00F00000);
      send(32'h01800000, 1'b1, 32'h00E00000);
      send(32'hFB000000, 1'b0, 32'h00040000);
      send(32'hFD000000, 1'b1, 32'hFF000000);
      drain();
      chk("stream_run", max_run, 32'd8);
      i_ready = 1'b0;
      send(32'h00000000, 1'b0, 32'h00800000);
      send(32'h7FFFFFFF, 1'b1, 32'h01000000);
      send(32'hFF000000, 1'b0, 32'h00400000);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_o_ready", {31'd0, o_ready}, 32'd0);
         chk("stall_o_valid", {31'd0, o_valid}, 32'd1);
         chk("stall_o_data", o_data, 32'h00800000);
      end
      @(posedge clk);
      #1;
      i_ready = 1'b1;
      drain();
      i_ready = 1'b0;
      send(32'h01000000, 1'b0, 32'h00C00000);
      send(32'h02000000, 1'b0, 32'h00E00000);
      send(32'h03000000, 1'b0, 32'h00F00000);
      rst = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      i_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("flushed_o_valid", {31'd0, o_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      i_data = 32'h01800000;
      i_mode = 1'b0;
      i_valid = 1'b1;
      exp_q.push_back(32'h00D00000);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         i_valid = 1'b0;
         if (o_valid) begin
            lat = k;
            break;
         end
      end
      chk("latency", lat, 32'd3);
`ifdef PWL_SEG_OUT_EN
      chk("o_seg", {29'd0, o_seg}, 32'd1);
`endif
      drain();
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pwl_activation_pipe.md
Name: pwl_activation_pipe

Overview:
- Pipelined, parametrised piecewise-linear (PWL) activation unit for the LSTM datapath.
- Per sample, selects sigmoid or tanh and classifies |x| into one of six segments: five linear, one saturated.
- Evaluates slope·|x| + intercept and applies odd/complement symmetry for negative inputs.
- 3-stage pipeline with valid/ready handshake on both sides; sits between gate accumulators and the cell-state/output multipliers.

Parameters:
- WIDTH, 32: data width, signed two's complement fixed point.
- FRAC, 24: fractional bits. Legal range: WIDTH-FRAC >= 4 and FRAC >= 6, so that 6.0 and 2^-6 are representable.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- i_data, input, WIDTH: operand x.
- i_mode, input, 1: 0 = sigmoid, 1 = tanh; captured per sample.
- i_valid, input, 1: operand valid.
- o_ready, output, 1: unit accepts an operand this cycle.
- o_data, output, WIDTH: result y.
- o_valid, output, 1: result valid.
- i_ready, input, 1: downstream accepts the result.

Behaviour:
- Notation: ONE = 1<<FRAC. Constants scale with FRAC.
- Pipeline enable: en = !o_valid || i_ready. o_ready = en (combinational).
- All stages advance together when en=1 and hold when en=0.
- Input accepted when i_valid && o_ready.
- Latency: exactly 3 clocks from acceptance to o_valid with no stall. Throughput: 1 sample per clock.
- Stage 1:
  - neg = i_data[WIDTH-1]; a = |i_data|.
  - i_data = -2^(WIDTH-1) is forced to the saturated segment.
  - tanh mode: a = 2·a; if the shift overflows, force saturation.
  - Register a, neg, mode and valid.
- Stage 2, segment select on a (breakpoints at integer values of the scaled operand):
  - a < 1·ONE: seg 0, s = (a>>2) + 0.5.
  - a < 2·ONE: seg 1, s = (a>>3) + 0.625.
  - a < 3·ONE: seg 2, s = (a>>4) + 0.75.
  - a < 4·ONE: seg 3, s = (a>>5) + 0.84375.
  - a < 6·ONE: seg 4, s = (a>>6) + 0.90625.
  - otherwise: seg 7, s = ONE.
  - Shifts are logical on non-negative a; truncation only. s is continuous at every breakpoint.
- Stage 3, output:
  - sigmoid: y = neg ? ONE - s : s.
  - tanh: t = 2s - ONE; y = neg ? -t : t.
  - Register y and valid into o_data / o_valid.
- Result range: sigmoid in [0, ONE]; tanh in [-ONE, ONE]. No wrap is possible.
- o_data is held stable while o_valid && !i_ready.
- Reset values: o_valid = 0, o_data = 0, all internal valids and data = 0. o_ready = 1 in the cycle after rst deasserts.
- Reset mid-operation: all in-flight samples are discarded; no output is produced for them.
- i_valid=0 with en=1: a bubble propagates; o_valid drops after the sample ahead drains.
- Simultaneous accept and output handshake in the same cycle is legal and sustains full rate.

Optional Feature:
- Macro: PWL_SEG_OUT_EN.
- When defined:
  - Extra output o_seg [2:0] carries the segment index (0-4, or 7 = saturated) for the sample on o_data.
  - Pipelined alongside the data, reset to 0, held under stall.
- When undefined: the port and its registers do not exist. Data behaviour is identical.

Test Plan:
1. Reset: hold rst 2 cycles, then release -> o_valid=0, o_data=0, o_ready=1. Sigmoid x=0x00000000 accepted -> 3 clocks later o_data=0x00800000 (0.5).
2. Sigmoid breakpoints and symmetry:
   - x=0x01000000 -> 0x00C00000 (0.75).
   - x=0xFF000000 -> 0x00400000 (0.25).
   - x=0x04000000 -> 0x00F80000 (0.96875).
   - x=0x07000000 -> 0x01000000.
   - x=0x80000000 -> 0x00000000.
3. Tanh:
   - x=0x00800000 (0.5) -> 0x00800000.
   - x=0xFF800000 -> 0xFF800000.
   - x=0x7FFFFFFF -> 0x01000000 (overflow forces saturation).
4. Back-to-back stream: 8 consecutive operands with alternating i_mode, i_ready=1 -> 8 consecutive o_valid cycles, in order, each result matching the scoreboard model.
5. Stall: i_ready=0 for 5 cycles with 3 samples in flight -> o_ready=0, o_data stable, no sample lost or duplicated. Release -> results drain in order.
6. Reset mid-stream: assert rst with 3 samples in flight -> no o_valid for them after release. The next accepted sample has 3-clock latency. With PWL_SEG_OUT_EN defined, o_seg=1 for x=0x01800000.
